lcd_bus_capture: RTL and testbench

Receive-side counterpart of the LCD pixel writer. It samples the parallel RGB LCD bus (rgb, d_clk, disp_en, hsync, vsync, d_en) and recovers pixels with their x/y coordinates. It checks frame geometry and hands pixels downstream over a valid/ready stream. It is used in loopback benches and on-board self-test: its inputs are driven from GPIO pins wired back from the writer's outputs.

---
 rtl/lcd_pkg.sv | 38 +++
 rtl/lcd_capture_fifo.sv | 50 +++++
 rtl/lcd_bus_capture.sv | 175 +++++++++++++++++
 tb/tb_lcd_bus_capture.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// lcd_pkg: shared types, default geometry and CRC helper for the LCD bus capture block
//   rgb_t       : 24-bit pixel {r, g, b}
//   cap_entry_t : FIFO entry {rgb, x, y, sof, eol}
//   cap_state_e : capture state machine states
//   crc16_step  : CRC-16-CCITT (poly 0x1021) over one 24-bit pixel, MSB first
package lcd_pkg;
    localparam int H_ACTIVE_DEF = 480;
    localparam int V_ACTIVE_DEF = 272;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    typedef struct packed {
        rgb_t       rgb;
        logic [9:0] x;
        logic [8:0] y;
        logic       sof;
        logic       eol;
    } cap_entry_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_VS,
        ST_BLANK,
        ST_ACTIVE
    } cap_state_e;

    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic [23:0] data);
        logic [15:0] c;
        c = crc;
        for (int i = 23; i >= 0; i--)
            c = {c[14:0], 1'b0} ^ ((c[15] ^ data[i]) ? 16'h1021 : 16'h0000);
        return c;
    endfunction
endpackage

// File: rtl/lcd_capture_fifo.sv
// lcd_capture_fifo: 4-deep show-ahead FIFO of captured pixel entries, single clock
//   i_clk           : clock
//   i_flush         : synchronous clear (empties the FIFO)
//   i_push / i_din  : write request and entry
//   i_pop           : consume head entry (ignored when empty)
//   o_dout          : head entry, zero while empty
//   o_full, o_empty : occupancy flags
module lcd_capture_fifo
    import lcd_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_flush,
    input  logic       i_push,
    input  cap_entry_t i_din,
    input  logic       i_pop,
    output cap_entry_t o_dout,
    output logic       o_full,
    output logic       o_empty
);
    cap_entry_t r_mem [4];
    logic [1:0] r_wr;
    logic [1:0] r_rd;
    logic [2:0] r_cnt;
    logic       w_wr;
    logic       w_rd;

    assign o_full  = r_cnt[2];
    assign o_empty = r_cnt == 3'd0;
    assign w_rd    = i_pop & ~o_empty;
    // when full, the slot being written is the head being popped this same cycle
    assign w_wr    = i_push & (~o_full | w_rd);
    assign o_dout  = o_empty ? '0 : r_mem[r_rd];

    always_ff @(posedge i_clk) begin
        if (w_wr)
            r_mem[r_wr] <= i_din;
    end

    always_ff @(posedge i_clk) begin
        if (i_flush) begin
            r_wr  <= 2'd0;
            r_rd  <= 2'd0;
            r_cnt <= 3'd0;
        end else begin
            r_wr  <= r_wr + {1'b0, w_wr};
            r_rd  <= r_rd + {1'b0, w_rd};
            r_cnt <= r_cnt + {2'b0, w_wr} - {2'b0, w_rd};
        end
    end
endmodule

// File: rtl/lcd_bus_capture.sv
// lcd_bus_capture: samples a parallel RGB LCD bus, recovers pixels with x/y,
// checks frame geometry and streams pixels out over valid/ready.
//   clk_12mhz, rst (sync, active-low)
//   lcd_rgb/d_clk/disp_en/hsync/vsync/d_en : bus inputs, synchronous to clk_12mhz
//   pix_rgb/x/y/sof/eol, pix_valid, pix_ready : output pixel stream
//   frame_done : one-cycle pulse per completed frame
//   err_width/err_height/err_overflow : sticky geometry / drop flags
//   frame_crc : CRC-16-CCITT of last frame when LCD_CAPTURE_CRC_EN is defined, else 0
module lcd_bus_capture
    import lcd_pkg::*;
#(
    parameter int H_ACTIVE        = H_ACTIVE_DEF,
    parameter int V_ACTIVE        = V_ACTIVE_DEF,
    parameter int SYNC_ACTIVE_LOW = 1
) (
    input  logic        clk_12mhz,
    input  logic        rst,
    input  logic [23:0] lcd_rgb,
    input  logic        lcd_d_clk,
    input  logic        lcd_disp_en,
    input  logic        lcd_hsync,
    input  logic        lcd_vsync,
    input  logic        lcd_d_en,
    output logic [23:0] pix_rgb,
    output logic [9:0]  pix_x,
    output logic [8:0]  pix_y,
    output logic        pix_sof,
    output logic        pix_eol,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic        frame_done,
    output logic        err_width,
    output logic        err_height,
    output logic        err_overflow,
    output logic [15:0] frame_crc
);
    localparam logic [9:0] X_END  = 10'(H_ACTIVE);
    localparam logic [9:0] X_LAST = 10'(H_ACTIVE - 1);
    localparam logic [8:0] Y_END  = 9'(V_ACTIVE);

    rgb_t       r_rgb;
    logic       r_dclk, r_dclk_d, r_de, r_vs, r_den, r_den_d;
    cap_state_e r_state;
    logic [9:0] r_x;
    logic [8:0] r_y;
    logic       r_push, r_done, r_err_w, r_err_h, r_err_o;
    cap_entry_t r_ent;
    cap_entry_t w_head;
    logic       w_full, w_empty;
    logic       w_stb, w_vs, w_live, w_end, w_pix, w_take, w_line;
    logic       w_unused;

    // line timing is recovered from d_en, so hsync carries nothing needed here
    assign w_unused = lcd_hsync;

    always_ff @(posedge clk_12mhz) begin
        if (!rst) begin
            r_rgb    <= '0;
            r_dclk   <= 1'b0;
            r_dclk_d <= 1'b0;
            r_de     <= 1'b0;
            r_vs     <= 1'b0;
            r_den    <= 1'b0;
        end else begin
            r_rgb    <= lcd_rgb;
            r_dclk   <= lcd_d_clk;
            r_dclk_d <= r_dclk;
            r_de     <= lcd_disp_en;
            r_vs     <= lcd_vsync;
            r_den    <= lcd_d_en;
        end
    end

    assign w_stb  = r_dclk & ~r_dclk_d;
    assign w_vs   = (SYNC_ACTIVE_LOW != 0) ? ~r_vs : r_vs;
    assign w_live = r_de & w_stb & (r_state == ST_BLANK || r_state == ST_ACTIVE);
    // vsync takes priority over a pixel sampled on the same strobe
    assign w_end  = w_live & w_vs & (r_state == ST_ACTIVE);
    assign w_pix  = w_live & ~w_vs & r_den;
    assign w_take = w_pix & (r_x < X_END) & (r_y < Y_END);
    assign w_line = w_live & ~w_vs & ~r_den & r_den_d & (r_state == ST_ACTIVE);

    always_ff @(posedge clk_12mhz) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_x     <= 10'd0;
            r_y     <= 9'd0;
            r_den_d <= 1'b0;
            r_push  <= 1'b0;
            r_ent   <= '0;
            r_done  <= 1'b0;
            r_err_w <= 1'b0;
            r_err_h <= 1'b0;
            r_err_o <= 1'b0;
        end else begin
            r_push <= w_take;
            r_done <= w_end;
            if (w_take)
                r_ent <= {r_rgb, r_x, r_y, r_x == 10'd0 && r_y == 9'd0, r_x == X_LAST};
            if (w_stb)
                r_den_d <= r_den;
            if ((w_pix && r_x >= X_END) || (w_line && r_x != X_END))
                r_err_w <= 1'b1;
            if (w_end && r_y != Y_END)
                r_err_h <= 1'b1;
            // a pop in the same cycle frees the head slot, so it is not an overflow
            if (r_push && w_full && !pix_ready)
                r_err_o <= 1'b1;
            // counters saturate one past the limit so overlong lines/frames stay flagged
            if (!r_de || w_end || w_line)
                r_x <= 10'd0;
            else if (w_pix && r_x <= X_END)
                r_x <= r_x + 10'd1;
            if (!r_de || w_end)
                r_y <= 9'd0;
            else if (w_line && r_y <= Y_END)
                r_y <= r_y + 9'd1;
            if (!r_de)
                r_state <= ST_IDLE;
            else if (r_state == ST_IDLE)
                r_state <= ST_WAIT_VS;
            else if (r_state == ST_WAIT_VS && w_stb && w_vs)
                r_state <= ST_BLANK;
            else if (r_state == ST_BLANK && w_pix)
                r_state <= ST_ACTIVE;
            else if (w_end)
                r_state <= ST_BLANK;
        end
    end

    lcd_capture_fifo u_fifo (
        .i_clk   (clk_12mhz),
        .i_flush (~rst),
        .i_push  (r_push),
        .i_din   (r_ent),
        .i_pop   (pix_ready),
        .o_dout  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign pix_rgb      = w_head.rgb;
    assign pix_x        = w_head.x;
    assign pix_y        = w_head.y;
    assign pix_sof      = w_head.sof;
    assign pix_eol      = w_head.eol;
    assign pix_valid    = ~w_empty;
    assign frame_done   = r_done;
    assign err_width    = r_err_w;
    assign err_height   = r_err_h;
    assign err_overflow = r_err_o;

`ifdef LCD_CAPTURE_CRC_EN
    logic [15:0] r_crc;
    logic [15:0] r_frame_crc;

    always_ff @(posedge clk_12mhz) begin
        if (!rst) begin
            r_crc       <= 16'hFFFF;
            r_frame_crc <= 16'h0000;
        end else if (!r_de) begin
            r_crc <= 16'hFFFF;
        end else if (w_end) begin
            r_frame_crc <= r_crc;
            r_crc       <= 16'hFFFF;
        end else if (w_take) begin
            r_crc <= crc16_step(r_crc, r_rgb);
        end
    end

    assign frame_crc = r_frame_crc;
`else
    assign frame_crc = 16'h0000;
`endif
endmodule

// File: tb/tb_lcd_bus_capture.sv
// tb_lcd_bus_capture: directed bench for lcd_bus_capture with H_ACTIVE=4, V_ACTIVE=3,
// d_clk = clk/2; checks CRC against a byte-wise model when LCD_CAPTURE_CRC_EN is defined
module tb_lcd_bus_capture;
    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] lcd_rgb;
    logic        lcd_d_clk, lcd_disp_en, lcd_hsync, lcd_vsync, lcd_d_en;
    logic [23:0] pix_rgb;
    logic [9:0]  pix_x;
    logic [8:0]  pix_y;
    logic        pix_sof, pix_eol, pix_valid, pix_ready;
    logic        frame_done, err_width, err_height, err_overflow;
    logic [15:0] frame_crc;

    int          n_asrt = 0;
    int          n_fail = 0;
    logic [44:0] q[$];
    int          fd_hi = 0;
    int          fd_rise = 0;
    logic        fd_prev = 1'b0;
    int          qb, r0, h0;
    logic [15:0] exp_crc;

    always #5 clk = ~clk;

    lcd_bus_capture #(.H_ACTIVE(4), .V_ACTIVE(3), .SYNC_ACTIVE_LOW(1)) dut (
        .clk_12mhz    (clk),
        .rst          (rst),
        .lcd_rgb      (lcd_rgb),
        .lcd_d_clk    (lcd_d_clk),
        .lcd_disp_en  (lcd_disp_en),
        .lcd_hsync    (lcd_hsync),
        .lcd_vsync    (lcd_vsync),
        .lcd_d_en     (lcd_d_en),
        .pix_rgb      (pix_rgb),
        .pix_x        (pix_x),
        .pix_y        (pix_y),
        .pix_sof      (pix_sof),
        .pix_eol      (pix_eol),
        .pix_valid    (pix_valid),
        .pix_ready    (pix_ready),
        .frame_done   (frame_done),
        .err_width    (err_width),
        .err_height   (err_height),
        .err_overflow (err_overflow),
        .frame_crc    (frame_crc)
    );

    always @(negedge clk) begin
        if (pix_valid && pix_ready)
            q.push_back({pix_rgb, pix_x, pix_y, pix_sof, pix_eol});
        if (frame_done)
            fd_hi++;
        if (frame_done && !fd_prev)
            fd_rise++;
        fd_prev = frame_done;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [44:0] ent(input int rgb, input int x, input int y);
        return {24'(rgb), 10'(x), 9'(y), x == 0 && y == 0, x == 3};
    endfunction

`ifdef LCD_CAPTURE_CRC_EN
    function automatic logic [15:0] ref_crc(input int npix);
        logic [15:0] c;
        c = 16'hFFFF;
        for (int i = 0; i < npix * 3; i++) begin
            c = c ^ 16'hFF00;
            for (int b = 0; b < 8; b++)
                c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
        end
        return c;
    endfunction
`endif

    task automatic settle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic px(input bit den, input bit vs, input logic [23:0] rgb);
        lcd_d_clk = 1'b0;
        lcd_d_en  = den;
        lcd_vsync = ~vs;
        lcd_rgb   = rgb;
        @(posedge clk);
        @(negedge clk);
        lcd_d_clk = 1'b1;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic vs_pulse();
        px(1'b0, 1'b1, 24'h0);
        px(1'b0, 1'b1, 24'h0);
        px(1'b0, 1'b0, 24'h0);
    endtask

    task automatic send_lines(input int nl, input int wide, input bit ones, input bit lat);
        int cnt;
        cnt = 0;
        for (int l = 0; l < nl; l++) begin
            for (int p = 0; p < ((l == wide) ? 5 : 4); p++) begin
                px(1'b1, 1'b0, ones ? 24'hFFFFFF : 24'(cnt));
                cnt++;
                if (lat && cnt == 1) begin
                    check("lat_n", pix_valid, 0);
                    @(negedge clk);
                    check("lat_n1", pix_valid, 0);
                    @(negedge clk);
                    check("lat_n2", {pix_valid, pix_sof, pix_rgb}, {1'b1, 1'b1, 24'h0});
                end
            end
            px(1'b0, 1'b0, 24'hABCDEF);
            px(1'b0, 1'b0, 24'hABCDEF);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        settle(3);
        rst = 1'b1;
        settle(1);
        qb = q.size();
        r0 = fd_rise;
        h0 = fd_hi;
    endtask

    initial begin
        rst = 1'b0;
        lcd_rgb = 24'h0;
        lcd_d_clk = 1'b0;
        lcd_disp_en = 1'b0;
        lcd_hsync = 1'b1;
        lcd_vsync = 1'b1;
        lcd_d_en = 1'b0;
        pix_ready = 1'b1;
        settle(3);
        check("rst_valid", pix_valid, 0);
        check("rst_pix", {pix_rgb, pix_x, pix_y, pix_sof, pix_eol}, 0);
        check("rst_flags", {frame_done, err_width, err_height, err_overflow}, 0);
        check("rst_crc", frame_crc, 0);

        // 1: clean frame, including the two-cycle first-pixel latency
        lcd_disp_en = 1'b1;
        do_reset();
        vs_pulse();
        send_lines(3, -1, 1'b0, 1'b1);
        vs_pulse();
        settle(8);
        check("t1_count", q.size() - qb, 12);
        for (int i = 0; i < 12; i++)
            check($sformatf("t1_pix%0d", i), q[qb + i], ent(i, i % 4, i / 4));
        check("t1_fd_pulses", fd_rise - r0, 1);
        check("t1_fd_width", fd_hi - h0, 1);
        check("t1_errs", {err_width, err_height, err_overflow}, 0);

        // 2: five pixels on line 1
        do_reset();
        vs_pulse();
        send_lines(3, 1, 1'b0, 1'b0);
        vs_pulse();
        settle(8);
        check("t2_count", q.size() - qb, 12);
        check("t2_line1_last", q[qb + 7], ent(7, 3, 1));
        check("t2_line2_first", q[qb + 8], ent(9, 0, 2));
        check("t2_line2_last", q[qb + 11], ent(12, 3, 2));
        check("t2_errs", {err_width, err_height, err_overflow}, 3'b100);

        // 3: short frame
        do_reset();
        vs_pulse();
        send_lines(2, -1, 1'b0, 1'b0);
        vs_pulse();
        settle(8);
        check("t3_count", q.size() - qb, 8);
        check("t3_fd_pulses", fd_rise - r0, 1);
        check("t3_errs", {err_width, err_height, err_overflow}, 3'b010);

        // 4: ready held low for a whole frame
        do_reset();
        pix_ready = 1'b0;
        vs_pulse();
        send_lines(3, -1, 1'b0, 1'b0);
        vs_pulse();
        settle(4);
        check("t4_head", {pix_valid, pix_rgb, pix_x, pix_y, pix_sof, pix_eol}, {1'b1, ent(0, 0, 0)});
        check("t4_ovf", {err_width, err_height, err_overflow}, 3'b001);
        settle(5);
        check("t4_head_hold", {pix_valid, pix_rgb, pix_x, pix_y, pix_sof, pix_eol}, {1'b1, ent(0, 0, 0)});
        @(posedge clk);
        #1 pix_ready = 1'b1;
        settle(8);
        check("t4_count", q.size() - qb, 4);
        for (int i = 0; i < 4; i++)
            check($sformatf("t4_pix%0d", i), q[qb + i], ent(i, i, 0));
        check("t4_drained", pix_valid, 0);

        // 5: disp_en dropped after the fifth pixel
        do_reset();
        vs_pulse();
        send_lines(1, -1, 1'b0, 1'b0);
        px(1'b1, 1'b0, 24'h4);
        lcd_disp_en = 1'b0;
        px(1'b0, 1'b0, 24'h0);
        px(1'b0, 1'b0, 24'h0);
        px(1'b0, 1'b0, 24'h0);
        settle(6);
        check("t5_kept", q.size() - qb, 5);
        check("t5_pix4", q[qb + 4], ent(4, 0, 1));
        check("t5_no_fd", fd_rise - r0, 0);
        check("t5_no_err", {err_width, err_height, err_overflow}, 0);
        lcd_disp_en = 1'b1;
        send_lines(1, -1, 1'b1, 1'b0);
        vs_pulse();
        send_lines(3, -1, 1'b0, 1'b0);
        vs_pulse();
        settle(8);
        check("t5_count", q.size() - qb, 17);
        check("t5_restart", q[qb + 5], ent(0, 0, 0));
        check("t5_end", q[qb + 16], ent(11, 3, 2));
        check("t5_fd", fd_rise - r0, 1);
        check("t5_errs", {err_width, err_height, err_overflow}, 0);

        // 6: CRC over all-ones frames, twice
`ifdef LCD_CAPTURE_CRC_EN
        exp_crc = ref_crc(12);
`else
        exp_crc = 16'h0000;
`endif
        do_reset();
        vs_pulse();
        send_lines(3, -1, 1'b1, 1'b0);
        vs_pulse();
        settle(4);
        check("t6_crc1", frame_crc, exp_crc);
        send_lines(3, -1, 1'b1, 1'b0);
        vs_pulse();
        settle(4);
        check("t6_crc2", frame_crc, exp_crc);
        check("t6_fd", fd_rise - r0, 2);

        // 7: reset taken mid-frame with a full FIFO
        do_reset();
        pix_ready = 1'b0;
        vs_pulse();
        send_lines(2, -1, 1'b0, 1'b0);
        check("t7_pre", {pix_valid, err_overflow}, 2'b11);
        rst = 1'b0;
        settle(1);
        check("t7_flush", {pix_valid, err_overflow, err_width, err_height}, 0);
        pix_ready = 1'b1;
        rst = 1'b1;
        qb = q.size();
        send_lines(1, -1, 1'b0, 1'b0);
        settle(6);
        check("t7_wait_vs", q.size() - qb, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end
endmodule
